reduce_tree_pipe: RTL

//  Pipelined, parametrised bit-reduction unit for the execute/branch path.

---
 rtl/reduce_pkg.sv | 48 ++++
 rtl/reduce_node.sv | 25 ++
 rtl/reduce_tree_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined bit-reduction tree.
//   red_mode_e   : reduction mode encodings (match the 2-bit in_mode port)
//   clog_base    : tree depth needed to reduce n inputs with b-input nodes
//   node_count   : number of nodes on tree level k (level 0 is the operand)
//   level_offset : bit offset of level k inside the flattened stage register
//   identity     : padding value that leaves a node's result unchanged
package reduce_pkg;

  typedef enum logic [1:0] {
    RED_ZERO = 2'b00,
    RED_OR   = 2'b01,
    RED_AND  = 2'b10,
    RED_XOR  = 2'b11
  } red_mode_e;

  function automatic int clog_base(input int n, input int b);
    int    k;
    longint p;
    k = 0;
    p = 1;
    while (p < n) begin
      p = p * b;
      k++;
    end
    return k;
  endfunction

  function automatic int node_count(input int width, input int fanin, input int k);
    longint p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * fanin;
    return int'((width + p - 1) / p);
  endfunction

  // Levels 1..k-1 are packed back to back, level 1 at bit 0.
  function automatic int level_offset(input int width, input int fanin, input int k);
    int s;
    s = 0;
    for (int j = 1; j < k; j++) s += node_count(width, fanin, j);
    return s;
  endfunction

  // ZERO is carried as OR through the tree, so only AND pads with 1.
  function automatic logic identity(input red_mode_e m);
    return (m == RED_AND);
  endfunction

endpackage

// File: rtl/reduce_node.sv
// Combinational FANIN-input reduction node.
//   in_bits : node inputs, already padded with the mode's identity value
//   mode    : reduction mode; ZERO reduces as OR (inversion happens at the root)
//   out_bit : reduced value
module reduce_node
  import reduce_pkg::*;
#(
  parameter int FANIN = 6
) (
  input  logic [FANIN-1:0] in_bits,
  input  red_mode_e        mode,
  output logic             out_bit
);

  always_comb begin
    // NOTE: give every always_comb output a value before any branch so no path can infer a latch.
    out_bit = |in_bits;
    case (mode)
      RED_AND: out_bit = &in_bits;
      RED_XOR: out_bit = ^in_bits;
      default: out_bit = |in_bits;
    endcase
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined, parametrised bit-reduction unit (ZERO / OR / AND / XOR).
// One register stage per tree level; all stages advance together whenever
// the output slot is empty or being consumed.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : kills every in-flight item on the next edge
//   in_valid/in_ready   : operand handshake; in_ready is the global advance
//   in_data/in_mode/in_tag : operand, mode, sideband tag
//   out_valid/out_ready : result handshake
//   out_result/out_tag  : reduction result and the tag that came with it
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FANIN = 6,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DEPTH  = clog_base(WIDTH, FANIN);
  localparam int LEVELS = (DEPTH < 1) ? 1 : DEPTH;
  // All level outputs live in one flat register; the root node is the top bit.
  localparam int TREE_W = level_offset(WIDTH, FANIN, LEVELS + 1);

  logic             valid_d [LEVELS];
  logic             valid_q [LEVELS];
  red_mode_e        mode_d  [LEVELS];
  red_mode_e        mode_q  [LEVELS];
  logic [TAG_W-1:0] tag_d   [LEVELS];
  logic [TAG_W-1:0] tag_q   [LEVELS];
  logic [TREE_W-1:0] tree_d;
  logic [TREE_W-1:0] tree_q;
  logic              adv;

  // Bubbles are not squeezed out: the whole pipe moves or the whole pipe holds.
  assign adv      = !valid_q[LEVELS-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      valid_d[k] = valid_q[k];
      mode_d[k]  = mode_q[k];
      tag_d[k]   = tag_q[k];
    end
    if (adv) begin
      valid_d[0] = in_valid;
      mode_d[0]  = red_mode_e'(in_mode);
      tag_d[0]   = in_tag;
      for (int k = 1; k < LEVELS; k++) begin
        valid_d[k] = valid_q[k-1];
        mode_d[k]  = mode_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end
    // Flush also swallows an operand offered in the same cycle.
    if (flush) begin
      for (int k = 0; k < LEVELS; k++) valid_d[k] = 1'b0;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_IN  = node_count(WIDTH, FANIN, k - 1);
    localparam int N_OUT = node_count(WIDTH, FANIN, k);
    localparam int PAD_W = N_OUT * FANIN;
    localparam int OFF   = level_offset(WIDTH, FANIN, k);

    logic [N_IN-1:0]  src;
    red_mode_e        src_mode;
    logic [PAD_W-1:0] padded;
    logic [N_OUT-1:0] node_out;
    logic [N_OUT-1:0] node_fin;

    // Level k reduces whatever stage k-1 holds, using that item's own mode.
    if (k == 1) begin : g_src_in
      assign src      = in_data;
      assign src_mode = red_mode_e'(in_mode);
    end else begin : g_src_prev
      localparam int PREV_OFF = level_offset(WIDTH, FANIN, k - 1);
      assign src      = tree_q[PREV_OFF +: N_IN];
      assign src_mode = mode_q[k-2];
    end

    always_comb begin
      padded           = {PAD_W{identity(src_mode)}};
      padded[N_IN-1:0] = src;
    end

    for (genvar n = 0; n < N_OUT; n++) begin : g_node
      reduce_node #(.FANIN(FANIN)) u_node (
        .in_bits (padded[n*FANIN +: FANIN]),
        .mode    (src_mode),
        .out_bit (node_out[n])
      );
    end

    // ZERO-detect is an OR tree with a single inversion at the root.
    if (k == LEVELS) begin : g_root
      assign node_fin = (src_mode == RED_ZERO) ? ~node_out : node_out;
    end else begin : g_inner
      assign node_fin = node_out;
    end

    assign tree_d[OFF +: N_OUT] = adv ? node_fin : tree_q[OFF +: N_OUT];
  end

  always_ff @(posedge clk) begin
    // NOTE: the tree data is reset along with the control so out_result/out_tag read 0 after reset.
    if (reset) begin
      tree_q <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        // NOTE: state registers use non-blocking assignment so every stage samples the pre-edge values.
        valid_q[k] <= 1'b0;
        mode_q[k]  <= RED_ZERO;
        tag_q[k]   <= '0;
      end
    end else begin
      tree_q <= tree_d;
      for (int k = 0; k < LEVELS; k++) begin
        valid_q[k] <= valid_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign out_valid  = valid_q[LEVELS-1];
  assign out_result = tree_q[TREE_W-1];
  assign out_tag    = tag_q[LEVELS-1];

endmodule
